// File: rtl/lbm_moments_stream.sv
// Purpose: D2Q9 moment extraction; turns one 144-bit population beat into rho/jx/jy (96-bit beat) and tracks frame length.
// Latency: 2 cycles from input handshake to m00_axis_tvalid; one cell per clock when downstream is ready.
// Backpressure: whole-pipeline stall; s00_axis_tready = !m00_axis_tvalid | m00_axis_tready (combinational).
module lbm_moments_stream #(
    parameter int CELLS     = 2500,
    parameter int CNT_WIDTH = 12
) (
    input  logic                 s00_axis_aclk,
    input  logic                 s00_axis_reset,
    input  logic [143:0]         s00_axis_tdata,
    input  logic                 s00_axis_tvalid,
    output logic                 s00_axis_tready,
    input  logic                 s00_axis_tlast,
    input  logic [17:0]          s00_axis_tstrb,
    output logic [95:0]          m00_axis_tdata,
    output logic                 m00_axis_tvalid,
    input  logic                 m00_axis_tready,
    output logic                 m00_axis_tlast,
    output logic                 frame_done,
    output logic                 frame_error,
    output logic [CNT_WIDTH-1:0] cell_count
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(CELLS - 1);

    // Byte strobes carry no information for this stream; every lane is always valid.
    logic tstrb_unused;
    assign tstrb_unused = ^s00_axis_tstrb;

    // Lane unpacking
    logic [15:0] f0, ln, lne, le, lse, ls, lsw, lw, lnw;
    assign f0  = s00_axis_tdata[15:0];
    assign ln  = s00_axis_tdata[31:16];
    assign lne = s00_axis_tdata[47:32];
    assign le  = s00_axis_tdata[63:48];
    assign lse = s00_axis_tdata[79:64];
    assign ls  = s00_axis_tdata[95:80];
    assign lsw = s00_axis_tdata[111:96];
    assign lw  = s00_axis_tdata[127:112];
    assign lnw = s00_axis_tdata[143:128];

    function automatic logic [17:0] sum3(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
        return {2'b00, a} + {2'b00, b} + {2'b00, c};
    endfunction

    logic advance, in_hs;
    assign advance         = !m00_axis_tvalid || m00_axis_tready;
    assign s00_axis_tready = advance;
    assign in_hs           = s00_axis_tvalid && advance;

    // Stage-1 state: rho reuses the x-axis triples, so only f0+n+s is extra.
    logic        s1_vld_q, s1_last_q;
    logic [17:0] s1_px_q, s1_nx_q, s1_py_q, s1_ny_q, s1_rc_q;

    // Stage-1 valid: a bubble is loaded whenever the pipeline advances without an input beat.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_reset) begin
            s1_vld_q <= 1'b0;
        end else if (advance) begin
            s1_vld_q <= in_hs;
        end
    end

    // Stage-1 partial sums: payload needs no reset, it is qualified by s1_vld_q.
    always_ff @(posedge s00_axis_aclk) begin
        if (advance) begin
            s1_last_q <= s00_axis_tlast;
            s1_px_q   <= sum3(le, lne, lse);
            s1_nx_q   <= sum3(lw, lnw, lsw);
            s1_py_q   <= sum3(ln, lne, lnw);
            s1_ny_q   <= sum3(ls, lse, lsw);
            s1_rc_q   <= sum3(f0, ln, ls);
        end
    end

    // Stage-2 combinational: final subtraction and packing with sign/zero extension.
    logic [19:0]        rho_w;
    logic signed [18:0] jx_w, jy_w;
    logic [95:0]        pack_w;
    always_comb begin
        rho_w  = {2'b00, s1_px_q} + {2'b00, s1_nx_q} + {2'b00, s1_rc_q};
        jx_w   = $signed({1'b0, s1_px_q}) - $signed({1'b0, s1_nx_q});
        jy_w   = $signed({1'b0, s1_py_q}) - $signed({1'b0, s1_ny_q});
        pack_w = {{13{jy_w[18]}}, jy_w, {13{jx_w[18]}}, jx_w, 12'd0, rho_w};
    end

    logic        m_vld_q, m_last_q;
    logic [95:0] m_dat_q;

    // Stage-2 / output register: held while a beat waits for m00_axis_tready.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_reset) begin
            m_vld_q  <= 1'b0;
            m_dat_q  <= '0;
            m_last_q <= 1'b0;
        end else if (advance) begin
            m_vld_q  <= s1_vld_q;
            m_dat_q  <= pack_w;
            m_last_q <= s1_last_q;
        end
    end

    assign m00_axis_tvalid = m_vld_q;
    assign m00_axis_tdata  = m_dat_q;
    assign m00_axis_tlast  = m_last_q;
    assign frame_done      = m_vld_q && m00_axis_tready && m_last_q && !s00_axis_reset;

    // Frame length tracking on the input side.
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    // Next-state for cell counter and sticky length error.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (in_hs) begin
            if (s00_axis_tlast) begin
                cnt_d = '0;
                if (cnt_q != LAST_IDX) begin
                    err_d = 1'b1;
                end
            end else if (cnt_q == LAST_IDX) begin
                cnt_d = '0;
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Counter and error registers.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cell_count  = cnt_q;
    assign frame_error = err_q;

endmodule

// File: tb/tb_lbm_moments_stream.sv
// Purpose: self-checking bench for lbm_moments_stream (directed vector table, random frames, stall/reset sequences).
// Latency: stimulus driven 1 time unit after posedge, DUT sampled on negedge.
// Backpressure: downstream ready is always-on, random or forced low depending on rdy_mode.
module tb_lbm_moments_stream;

    localparam int CELLS = 2500;
    localparam int CW    = 12;

    logic          clk;
    logic          rst;
    logic [143:0]  s_dat;
    logic          s_vld, s_last, s_rdy;
    logic [17:0]   s_strb;
    logic [95:0]   m_dat;
    logic          m_vld, m_rdy, m_last;
    logic          fdone, ferr;
    logic [CW-1:0] ccnt;

    lbm_moments_stream #(.CELLS(CELLS), .CNT_WIDTH(CW)) dut (
        .s00_axis_aclk  (clk),
        .s00_axis_reset (rst),
        .s00_axis_tdata (s_dat),
        .s00_axis_tvalid(s_vld),
        .s00_axis_tready(s_rdy),
        .s00_axis_tlast (s_last),
        .s00_axis_tstrb (s_strb),
        .m00_axis_tdata (m_dat),
        .m00_axis_tvalid(m_vld),
        .m00_axis_tready(m_rdy),
        .m00_axis_tlast (m_last),
        .frame_done     (fdone),
        .frame_error    (ferr),
        .cell_count     (ccnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
    int fd_cnt = 0;

    task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: moments straight from the lane definitions, in plain integers.
    function automatic logic [96:0] model(input logic [143:0] d, input logic last);
        int l[9];
        int rho, jx, jy;
        for (int k = 0; k < 9; k++) l[k] = int'(d[k*16 +: 16]);
        rho = 0;
        for (int k = 0; k < 9; k++) rho += l[k];
        jx = (l[3] + l[2] + l[4]) - (l[7] + l[8] + l[6]);
        jy = (l[1] + l[2] + l[8]) - (l[5] + l[4] + l[6]);
        return {last, jy[31:0], jx[31:0], rho[31:0]};
    endfunction

    function automatic logic [143:0] mk(input logic [15:0] f0, input logic [15:0] n,
        input logic [15:0] ne, input logic [15:0] e, input logic [15:0] se,
        input logic [15:0] s, input logic [15:0] sw, input logic [15:0] w,
        input logic [15:0] nw);
        return {nw, w, sw, s, se, e, ne, n, f0};
    endfunction

    function automatic logic [143:0] rand_beat();
        logic [143:0] d;
        for (int k = 0; k < 9; k++) d[k*16 +: 16] = 16'($urandom);
        return d;
    endfunction

    // Downstream ready generator.
    initial begin
        m_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_rdy = 1'b1;
                1:       m_rdy = 1'($urandom_range(0, 1));
                default: m_rdy = 1'b0;
            endcase
        end
    end

    // Scoreboard / monitor on the falling edge.
    logic [96:0] exp_q[$];
    int          mcnt = 0;
    logic        merr = 1'b0;
    logic        have_prev = 1'b0;
    logic        prev_vld, prev_rdy, prev_last;
    logic [95:0] prev_dat;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                mcnt = 0;
                merr = 1'b0;
                have_prev = 1'b0;
            end else begin
                logic [96:0] e;
                chk("cell_count", 96'(ccnt), 96'(mcnt));
                chk("frame_error", 96'(ferr), 96'(merr));
                if (have_prev && prev_vld && !prev_rdy) begin
                    chk("stall_tvalid", 96'(m_vld), 96'(1));
                    chk("stall_tdata", m_dat, prev_dat);
                    chk("stall_tlast", 96'(m_last), 96'(prev_last));
                end
                if (fdone) fd_cnt++;
                if (m_vld && m_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL stale_output: got beat %h expected none", m_dat);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_tdata", m_dat, e[95:0]);
                        chk("out_tlast", 96'(m_last), 96'(e[96]));
                        chk("frame_done_on_hs", 96'(fdone), 96'(e[96]));
                    end
                end else begin
                    chk("frame_done_idle", 96'(fdone), 96'(0));
                end
                if (s_vld && s_rdy) begin
                    exp_q.push_back(model(s_dat, s_last));
                    if (s_last) begin
                        if (mcnt != CELLS - 1) merr = 1'b1;
                        mcnt = 0;
                    end else if (mcnt == CELLS - 1) begin
                        merr = 1'b1;
                        mcnt = 0;
                    end else begin
                        mcnt++;
                    end
                end
                have_prev = 1'b1;
                prev_vld  = m_vld;
                prev_rdy  = m_rdy;
                prev_dat  = m_dat;
                prev_last = m_last;
            end
        end
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // All driver tasks start and end 1 time unit after a posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        s_vld = 1'b0;
        rst   = 1'b1;
        repeat (n) step();
        rst   = 1'b0;
    endtask

    task automatic send(input logic [143:0] d, input logic last, input int budget, output bit ok);
        s_dat  = d;
        s_last = last;
        s_vld  = 1'b1;
        ok     = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (s_rdy) ok = 1'b1;
            step();
        end
        s_vld = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            step();
            if (exp_q.size() == 0 && !m_vld) done = 1'b1;
        end
        chk("drain_complete", 96'(done), 96'(1));
    endtask

    task automatic run_frame(input int n, input int last_at);
        bit ok;
        for (int i = 1; i <= n; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            send(rand_beat(), (i == last_at), 200, ok);
            if (!ok) chk("send_timeout", 96'(ok), 96'(1));
        end
    endtask

    typedef struct {
        logic [143:0] dat;
        logic [31:0]  rho;
        logic [31:0]  jx;
        logic [31:0]  jy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit ok, ok0, ok1, ok2;
        int hs;

        tbl[0] = '{mk(16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1),
                   32'd9, 32'h0, 32'h0};
        tbl[1] = '{mk(16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0),
                   32'd196605, 32'h0002FFFD, 32'h0};
        tbl[2] = '{mk(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF),
                   32'd196605, 32'hFFFD0003, 32'h0};
        tbl[3] = '{mk(16'h0, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF),
                   32'd196605, 32'h0, 32'h0002FFFD};
        tbl[4] = '{mk(16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0),
                   32'd196605, 32'h0, 32'hFFFD0003};
        tbl[5] = '{mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                      16'hFFFF, 16'hFFFF), 32'd589815, 32'h0, 32'h0};
        tbl[6] = '{mk(16'h1234, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
                   32'h1235, 32'h0, 32'h1};
        tbl[7] = '{mk(16'h0, 16'h0, 16'h0, 16'h3, 16'h0, 16'h0, 16'h0, 16'h5, 16'h0),
                   32'd8, 32'hFFFFFFFE, 32'h0};

        s_dat  = '0;
        s_vld  = 1'b0;
        s_last = 1'b0;
        s_strb = '1;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        do_reset(3);

        // Reset state
        @(negedge clk);
        chk("rst_tvalid", 96'(m_vld), 96'(0));
        chk("rst_tdata", m_dat, 96'(0));
        chk("rst_tlast", 96'(m_last), 96'(0));
        chk("rst_frame_done", 96'(fdone), 96'(0));
        chk("rst_frame_error", 96'(ferr), 96'(0));
        chk("rst_cell_count", 96'(ccnt), 96'(0));
        chk("rst_s_tready", 96'(s_rdy), 96'(1));
        step();

        // Directed vectors: exact latency and value of each beat in isolation.
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].dat, 1'b0, 5, ok);
            chk("vec_accept", 96'(ok), 96'(1));
            @(negedge clk);
            chk("vec_lat1_tvalid", 96'(m_vld), 96'(0));
            chk("vec_cell_count", 96'(ccnt), 96'(i + 1));
            step();
            @(negedge clk);
            chk("vec_lat2_tvalid", 96'(m_vld), 96'(1));
            chk("vec_tdata", m_dat, {tbl[i].jy, tbl[i].jx, tbl[i].rho});
            step();
            @(negedge clk);
            chk("vec_one_cycle", 96'(m_vld), 96'(0));
            step();
        end

        // Stall: downstream never ready, three beats offered.
        do_reset(2);
        rdy_mode = 2;
        step();
        step();
        send(rand_beat(), 1'b0, 5, ok0);
        send(rand_beat(), 1'b0, 5, ok1);
        send(rand_beat(), 1'b0, 5, ok2);
        chk("stall_accepted", 96'(int'(ok0) + int'(ok1) + int'(ok2)), 96'(2));
        @(negedge clk);
        chk("stall_s_tready", 96'(s_rdy), 96'(0));
        step();
        rdy_mode = 1;
        send(rand_beat(), 1'b0, 200, ok);
        chk("stall_resume_accept", 96'(ok), 96'(1));
        drain();

        // Full frame with random backpressure.
        do_reset(2);
        fd_cnt = 0;
        run_frame(CELLS, CELLS);
        drain();
        chk("frame_done_count", 96'(fd_cnt), 96'(1));
        chk("frame_ok_error", 96'(ferr), 96'(0));
        chk("frame_ok_count", 96'(ccnt), 96'(0));

        // Short frame then a good frame: error must stick.
        run_frame(10, 10);
        drain();
        chk("short_frame_error", 96'(ferr), 96'(1));
        run_frame(CELLS, CELLS);
        drain();
        chk("error_sticky", 96'(ferr), 96'(1));

        // Reset with two beats in flight.
        rdy_mode = 0;
        step();
        step();
        send(rand_beat(), 1'b0, 5, ok0);
        send(rand_beat(), 1'b0, 5, ok1);
        chk("inflight_accept", 96'(int'(ok0) + int'(ok1)), 96'(2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tvalid", 96'(m_vld), 96'(0));
        chk("midrst_cell_count", 96'(ccnt), 96'(0));
        chk("midrst_frame_error", 96'(ferr), 96'(0));
        step();
        hs = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_vld && m_rdy) hs++;
            step();
        end
        chk("midrst_no_stale", 96'(hs), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lbm_moments_stream.md
Name: lbm_moments_stream

Overview:
- Downstream consumer of the 144-bit lattice distribution stream produced by the BRAM read controller.
- Each beat carries the nine D2Q9 populations of one cell.
- Computes that cell's macroscopic moments: density rho and momentum jx, jy.
- Emits one 96-bit moment beat per cell on an output AXI-stream, plus frame bookkeeping for the downstream writer or visualisation stage.

Parameters:
- CELLS, 2500, lattice cells per frame; input beats between tlast markers.
- CNT_WIDTH, 12, width of the cell counter; must satisfy 2^CNT_WIDTH >= CELLS.

Ports:
- s00_axis_aclk  in  1  single clock for all logic.
- s00_axis_reset  in  1  synchronous, active-high reset.
- s00_axis_tdata  in  144  lanes of 16 bits, unsigned: [15:0]=f0 (rest), [31:16]=n, [47:32]=ne, [63:48]=e, [79:64]=se, [95:80]=s, [111:96]=sw, [127:112]=w, [143:128]=nw.
- s00_axis_tvalid  in  1  input beat valid.
- s00_axis_tready  out  1  input beat accepted when tvalid & tready.
- s00_axis_tlast  in  1  marks last cell of frame.
- s00_axis_tstrb  in  18  ignored; all bytes treated as valid.
- m00_axis_tdata  out  96  [31:0]=rho zero-extended, [63:32]=jx sign-extended, [95:64]=jy sign-extended.
- m00_axis_tvalid  out  1  output beat valid.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tlast  out  1  tlast carried with the cell.
- frame_done  out  1  one-cycle pulse when the output beat with tlast is accepted.
- frame_error  out  1  sticky; set on frame length mismatch.
- cell_count  out  CNT_WIDTH  accepted input beats in the current frame.

Behaviour:
- Reset (synchronous, active-high): all pipeline valids=0; m00_axis_tvalid=0, m00_axis_tdata=0, m00_axis_tlast=0, frame_done=0, frame_error=0, cell_count=0. s00_axis_tready=1 in the cycle after reset deasserts.
- Arithmetic:
  - rho = sum of all nine lanes; 20 bits unsigned (max 9*65535=589815).
  - jx = (e+ne+se) - (w+nw+sw).
  - jy = (n+ne+nw) - (s+se+sw).
  - jx and jy are 19-bit signed, range +/-196605. No saturation, no overflow possible.
- Pipeline, two stages:
  - Stage 1 registers the three partial sums for each of the positive group, the negative group and rho. The partial sums are the three 18-bit triples per axis, plus the rho partials.
  - Stage 2 registers the final subtraction and packing.
  - Latency: 2 cycles from input handshake to m00_axis_tvalid, with no stall.
- Flow control:
  - Whole-pipeline stall: advance = !m00_axis_tvalid | m00_axis_tready.
  - s00_axis_tready = advance, computed combinationally from stage-2 occupancy and m00_axis_tready.
  - When advance=0 all stage registers hold and m00_axis_tdata/tlast stay stable while tvalid=1 (AXI rule).
  - Bubbles: a stage with valid=0 is overwritten freely.
  - Full throughput: one cell per clock when m00_axis_tready is held high.
- Cell counter:
  - Increments on each input handshake.
  - On a handshake with tlast=1, the counter returns to 0.
  - If cell_count==CELLS-1 and tlast=0: set frame_error, then wrap the counter to 0.
  - If tlast=1 and cell_count!=CELLS-1: set frame_error, then restart at 0.
  - frame_error is sticky and cleared only by reset.
- frame_done:
  - Asserted for exactly one cycle on m00 handshake with m00_axis_tlast=1.
  - Not asserted during stalls.
- Reset mid-frame: the pipeline is flushed and partial output discarded. The next accepted beat counts as cell 0.
- Simultaneous input handshake and output handshake in the same cycle is legal and required for full throughput.

Test Plan:
- Single beat, all lanes=16'h0001, tlast=0, m tready=1 -> after 2 cycles tdata rho=9, jx=0, jy=0, tvalid for 1 cycle; cell_count=1.
- Beat e=ne=se=16'hFFFF, others 0 -> rho=196605, jx=32'h0002FFFD, jy=0; mirror with w/nw/sw=16'hFFFF -> jx=32'hFFFD0003 (-196605).
- Stream 2500 beats with random data, tlast on the 2500th, m tready toggled randomly (about 50%) -> outputs match scoreboard in order and are stable while stalled; one frame_done pulse coinciding with the tlast output handshake; frame_error=0; cell_count=0 afterwards.
- Hold m00_axis_tready=0 with 3 beats offered -> at most 2 accepted; s00_axis_tready=0 thereafter; no data lost after tready returns to 1.
- tlast on beat 10 (CELLS=2500) -> frame_error=1 and stays 1; next frame of 2500 beats still produces correct data; error cleared only by s00_axis_reset.
- Assert s00_axis_reset for 1 cycle mid-frame with 2 beats in flight -> m00_axis_tvalid=0 next cycle, cell_count=0, frame_error=0, no stale beats emitted afterward.
